// File: rtl/lane_scatter_16.sv
// Serial-to-parallel lane packer: gathers signed operands from a valid/ready stream
// into a zero-padded LANES-wide vector for the adder tree, with a one-vector stall buffer.
module lane_scatter_16 #(
    parameter int WIDTH = 32,
    parameter int LANES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic signed [WIDTH-1:0] out_data [0:LANES-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_count
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic {FILL, FULL} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] fill_buf [0:LANES-1];
    logic signed [WIDTH-1:0] vec_done [0:LANES-1];
    logic                    accept;
    logic                    complete;
    logic                    out_free;
    logic [4:0]              done_count;

    // Lane of the completed vector: buffered element, the completing element, or signed zero.
    function automatic logic signed [WIDTH-1:0] pad_lane(
        input int                      lane,
        input logic [IDX_W-1:0]        last_idx,
        input logic signed [WIDTH-1:0] buf_val,
        input logic signed [WIDTH-1:0] new_val
    );
        if (lane < int'(last_idx)) begin
            return buf_val;
        end else if (lane == int'(last_idx)) begin
            return new_val;
        end
        return '0;
    endfunction

    assign accept     = in_valid && in_ready;
    assign complete   = accept && (in_last || (idx == IDX_W'(LANES - 1)));
    assign out_free   = !out_valid || out_ready;
    assign done_count = 5'(idx) + 5'd1;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            vec_done[i] = pad_lane(i, idx, fill_buf[i], in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (complete && !out_free) state_nxt = FULL;
            FULL:    if (out_ready)             state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL) && !rst;
    end

    // In FULL the fill buffer doubles as the stall register; idx still points at its last lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                fill_buf[i] <= '0;
                out_data[i] <= '0;
            end
        end else if (state == FILL) begin
            if (complete) begin
                if (out_free) begin
                    out_data  <= vec_done;
                    out_count <= done_count;
                    out_valid <= 1'b1;
                    idx       <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        fill_buf[i] <= '0;
                    end
                end else begin
                    fill_buf[idx] <= in_data;
                end
            end else begin
                if (accept) begin
                    fill_buf[idx] <= in_data;
                    idx           <= idx + 1'b1;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end else if (out_ready) begin
            out_data  <= fill_buf;
            out_count <= done_count;
            idx       <= '0;
            for (int i = 0; i < LANES; i++) begin
                fill_buf[i] <= '0;
            end
        end
    end

endmodule
